// File: rtl/branch_pc_unit.sv
// Program-counter stage: resolves branch conditions, selects and registers the next PC,
// halts on a misaligned taken target and counts retired instructions.
module branch_pc_unit #(
  parameter int unsigned    XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      BrOp,
  input  logic [XLEN-1:0] RS1Data,
  input  logic [XLEN-1:0] RS2Data,
  input  logic [XLEN-1:0] ALURes,
  input  logic            Stall,
  output logic [XLEN-1:0] PC,
  output logic [XLEN-1:0] PCPlus4,
  output logic            BrTaken,
  output logic            Halted,
  output logic            MisalignTrap,
  output logic [31:0]     InstrCount
);

  typedef enum logic {RUN, HALT} state_t;

  state_t          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [31:0]     count_q, count_d;
  logic            trap_q, trap_d;

  logic            condTrue;
  logic [XLEN-1:0] target;
  logic [XLEN-1:0] nextPc;
  logic            misalign;

  always_comb begin
    condTrue = 1'b0;
    unique case (BrOp[2:0])
      3'b000:  condTrue = (RS1Data == RS2Data);
      3'b001:  condTrue = (RS1Data != RS2Data);
      3'b100:  condTrue = ($signed(RS1Data) <  $signed(RS2Data));
      3'b101:  condTrue = ($signed(RS1Data) >= $signed(RS2Data));
      3'b110:  condTrue = (RS1Data <  RS2Data);
      3'b111:  condTrue = (RS1Data >= RS2Data);
      default: condTrue = 1'b0;
    endcase
  end

  // Clearing bit0 of the target gives JALR semantics and is harmless for B/J targets.
  assign BrTaken  = ((BrOp[4:3] == 2'b01) && condTrue) || (BrOp == 5'b10000);
  assign target   = {ALURes[XLEN-1:1], 1'b0};
  assign PCPlus4  = pc_q + XLEN'(4);
  assign nextPc   = BrTaken ? target : PCPlus4;
  assign misalign = BrTaken && target[1];

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    count_d = count_q;
    trap_d  = trap_q;
    // A faulting jump leaves the PC on the offending instruction so it stays visible.
    if (state_q == RUN && !Stall) begin
      if (misalign) begin
        trap_d  = 1'b1;
        state_d = HALT;
      end else begin
        pc_d    = nextPc;
        count_d = count_q + 32'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= RUN;
      pc_q    <= RESET_PC;
      count_q <= '0;
      trap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      count_q <= count_d;
      trap_q  <= trap_d;
    end
  end

  assign PC           = pc_q;
  assign Halted       = (state_q == HALT);
  assign MisalignTrap = trap_q;
  assign InstrCount   = count_q;

endmodule

// File: tb/tb_branch_pc_unit.sv
// Directed testbench for branch_pc_unit: hand-computed PC, flag and counter values
// across branches, jumps, stalls, wrap-around and the misalign halt.
module tb_branch_pc_unit;

  logic        clk;
  logic        rst;
  logic [4:0]  BrOp;
  logic [31:0] RS1Data;
  logic [31:0] RS2Data;
  logic [31:0] ALURes;
  logic        Stall;
  logic [31:0] PC;
  logic [31:0] PCPlus4;
  logic        BrTaken;
  logic        Halted;
  logic        MisalignTrap;
  logic [31:0] InstrCount;

  int assertCount = 0;
  int failCount   = 0;

  branch_pc_unit #(.XLEN(32), .RESET_PC(32'h0000_0000)) dut (
    .clk          (clk),
    .rst          (rst),
    .BrOp         (BrOp),
    .RS1Data      (RS1Data),
    .RS2Data      (RS2Data),
    .ALURes       (ALURes),
    .Stall        (Stall),
    .PC           (PC),
    .PCPlus4      (PCPlus4),
    .BrTaken      (BrTaken),
    .Halted       (Halted),
    .MisalignTrap (MisalignTrap),
    .InstrCount   (InstrCount)
  );

  // 10 ns core clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compares one observed value against its hand-computed expectation
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drives one set of inputs and lets combinational outputs settle
  task automatic applyStimulus(input logic [4:0] op, input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [31:0] alu, input logic stl);
    BrOp    = op;
    RS1Data = rs1;
    RS2Data = rs2;
    ALURes  = alu;
    Stall   = stl;
    #1;
  endtask

  // Advances one rising edge and waits past it before sampling
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic checkState(input string tag, input logic [31:0] pc, input logic [31:0] cnt,
                            input logic halted, input logic trap);
    checkOutput({tag, ".PC"},    PC,                  pc);
    checkOutput({tag, ".Count"}, InstrCount,          cnt);
    checkOutput({tag, ".Halt"},  {31'd0, Halted},       {31'd0, halted});
    checkOutput({tag, ".Trap"},  {31'd0, MisalignTrap}, {31'd0, trap});
  endtask

  initial begin
    rst = 1'b1;
    applyStimulus(5'b00000, 32'd0, 32'd0, 32'd0, 1'b0);
    tick();
    rst = 1'b0;
    checkState("reset", 32'h0, 32'd0, 1'b0, 1'b0);

    // Sequential fetch
    tick(); checkOutput("seq1.PC", PC, 32'h4);
    tick(); checkOutput("seq2.PC", PC, 32'h8);
    tick(); checkState("seq3", 32'hC, 32'd3, 1'b0, 1'b0);
    tick(); checkOutput("seq4.PC", PC, 32'h10);

    // BEQ taken
    applyStimulus(5'b01000, 32'd5, 32'd5, 32'h40, 1'b0);
    checkOutput("beq.Taken", {31'd0, BrTaken}, 32'd1);
    checkOutput("beq.PCPlus4", PCPlus4, 32'h14);
    tick(); checkState("beq", 32'h40, 32'd5, 1'b0, 1'b0);

    // Jump back to 0x10, then BEQ not taken
    applyStimulus(5'b10000, 32'd0, 32'd0, 32'h10, 1'b0);
    tick(); checkOutput("jback.PC", PC, 32'h10);
    applyStimulus(5'b01000, 32'd5, 32'd6, 32'h40, 1'b0);
    checkOutput("beqnt.Taken", {31'd0, BrTaken}, 32'd0);
    tick(); checkState("beqnt", 32'h14, 32'd7, 1'b0, 1'b0);

    // BLT signed taken, BLTU not taken
    applyStimulus(5'b01100, 32'hFFFF_FFFF, 32'd1, 32'h80, 1'b0);
    checkOutput("blt.Taken", {31'd0, BrTaken}, 32'd1);
    tick(); checkOutput("blt.PC", PC, 32'h80);
    applyStimulus(5'b01110, 32'hFFFF_FFFF, 32'd1, 32'h80, 1'b0);
    checkOutput("bltu.Taken", {31'd0, BrTaken}, 32'd0);
    tick(); checkOutput("bltu.PC", PC, 32'h84);

    // BNE equal, BGE signed, BGEU, funct3=010, non-branch code 11000
    applyStimulus(5'b01001, 32'd3, 32'd3, 32'h300, 1'b0);
    checkOutput("bne.Taken", {31'd0, BrTaken}, 32'd0);
    tick(); checkOutput("bne.PC", PC, 32'h88);
    applyStimulus(5'b01101, 32'hFFFF_FFFF, 32'd1, 32'h300, 1'b0);
    checkOutput("bge.Taken", {31'd0, BrTaken}, 32'd0);
    tick(); checkOutput("bge.PC", PC, 32'h8C);
    applyStimulus(5'b01111, 32'hFFFF_FFFF, 32'd1, 32'h200, 1'b0);
    checkOutput("bgeu.Taken", {31'd0, BrTaken}, 32'd1);
    tick(); checkOutput("bgeu.PC", PC, 32'h200);
    applyStimulus(5'b01010, 32'd1, 32'd1, 32'h300, 1'b0);
    checkOutput("f010.Taken", {31'd0, BrTaken}, 32'd0);
    tick(); checkOutput("f010.PC", PC, 32'h204);
    applyStimulus(5'b11000, 32'd1, 32'd1, 32'h300, 1'b0);
    checkOutput("op11000.Taken", {31'd0, BrTaken}, 32'd0);
    tick(); checkState("op11000", 32'h208, 32'd14, 1'b0, 1'b0);

    // JALR with odd target: bit0 cleared, PCPlus4 reflects old PC
    applyStimulus(5'b10000, 32'd0, 32'd0, 32'h0000_0101, 1'b0);
    checkOutput("jalr.Taken", {31'd0, BrTaken}, 32'd1);
    checkOutput("jalr.PCPlus4", PCPlus4, 32'h20C);
    tick(); checkState("jalr", 32'h100, 32'd15, 1'b0, 1'b0);

    // Stall with a misaligned jump pending: nothing moves, no trap
    applyStimulus(5'b10000, 32'd0, 32'd0, 32'h22, 1'b1);
    checkOutput("stall.Taken", {31'd0, BrTaken}, 32'd1);
    tick(); tick();
    checkState("stall", 32'h100, 32'd15, 1'b0, 1'b0);

    // PC wrap-around
    applyStimulus(5'b10000, 32'd0, 32'd0, 32'hFFFF_FFFC, 1'b0);
    tick(); checkOutput("wrap0.PC", PC, 32'hFFFF_FFFC);
    applyStimulus(5'b00000, 32'd0, 32'd0, 32'd0, 1'b0);
    checkOutput("wrap.PCPlus4", PCPlus4, 32'h0);
    tick(); checkState("wrap", 32'h0, 32'd17, 1'b0, 1'b0);

    // Misaligned jump at PC=0x8 halts with the faulting PC held
    applyStimulus(5'b10000, 32'd0, 32'd0, 32'h9, 1'b0);
    tick(); checkOutput("tomis.PC", PC, 32'h8);
    applyStimulus(5'b10000, 32'd0, 32'd0, 32'h22, 1'b0);
    tick(); checkState("misal", 32'h8, 32'd18, 1'b1, 1'b1);

    // HALT ignores further stimulus, BrTaken stays combinational
    applyStimulus(5'b00000, 32'd0, 32'd0, 32'd0, 1'b0);
    tick();
    applyStimulus(5'b10000, 32'd0, 32'd0, 32'h40, 1'b1);
    checkOutput("halt.Taken", {31'd0, BrTaken}, 32'd1);
    tick();
    applyStimulus(5'b10000, 32'd0, 32'd0, 32'h40, 1'b0);
    tick(); checkState("halt", 32'h8, 32'd18, 1'b1, 1'b1);

    // Reset exits HALT even while stalled
    rst = 1'b1;
    applyStimulus(5'b10000, 32'd0, 32'd0, 32'h40, 1'b1);
    tick();
    rst = 1'b0;
    checkState("rsthalt", 32'h0, 32'd0, 1'b0, 1'b0);

    // Back in RUN after reset
    applyStimulus(5'b00000, 32'd0, 32'd0, 32'd0, 1'b0);
    tick(); checkState("rerun", 32'h4, 32'd1, 1'b0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
